// File: rtl/jtag_ir_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_ir_driver_if
// Brief    : Controller handshake plus 4-wire TAP pins for the IR loader.
// Revision : 1.0
// ============================================================================
interface jtag_ir_driver_if #(
    parameter int IR_WIDTH = 2
);
    logic                start;
    logic [IR_WIDTH-1:0] instr;
    logic                busy;
    logic                done;
    logic [IR_WIDTH-1:0] captured;
    logic                tck;
    logic                tms;
    logic                tdi;
    logic                tdo;

    // master: test controller plus target TAP; slave: the loader itself
    modport master (
        output start, instr, tdo,
        input  busy, done, captured, tck, tms, tdi
    );
    modport slave (
        input  start, instr, tdo,
        output busy, done, captured, tck, tms, tdi
    );
endinterface
`default_nettype wire

// File: rtl/jtag_ir_driver.sv
`default_nettype none
// ============================================================================
// Module   : jtag_ir_driver
// Brief    : Divides clk into TCK, walks the TAP to Shift-IR, loads one
//            instruction LSB first and returns the IR capture bits.
// Revision : 1.0
// ============================================================================
module jtag_ir_driver #(
    parameter int IR_WIDTH = 2,
    parameter int CLK_DIV  = 2
) (
    input  logic              clk,
    input  logic              rst,
    jtag_ir_driver_if.slave   bus
);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (IR_WIDTH > 6) ? IR_WIDTH : 6;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(5);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(IR_WIDTH - 1);

    typedef enum logic [3:0] {
        RESET_SEQ = 4'd0,
        IDLE      = 4'd1,
        SEL_DR    = 4'd2,
        SEL_IR    = 4'd3,
        CAPTURE   = 4'd4,
        SHIFT     = 4'd5,
        EXIT1     = 4'd6,
        UPDATE    = 4'd7,
        RETURN    = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] shcap_q, shcap_d;
    logic [IR_WIDTH-1:0] captured_q, captured_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IR_WIDTH-1:0] cap_shift;
    logic                sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_SEQ;
            div_q      <= '0;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            sr_q       <= '0;
            shcap_q    <= '0;
            captured_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            shcap_q    <= shcap_d;
            captured_q <= captured_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        shcap_d    = shcap_q;
        captured_d = captured_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // tdo enters at the MSB so the first sampled bit ends up in bit 0
        cap_shift              = shcap_q >> 1;
        cap_shift[IR_WIDTH-1]  = bus.tdo;
        // SHIFT count 0 is the Capture-IR -> Shift-IR transition, not data
        sample = ((state_q == SHIFT) && (cnt_q != '0)) || (state_q == EXIT1);

        if (state_q == IDLE) begin
            busy_d = 1'b0;
            tck_d  = 1'b0;
            tms_d  = 1'b0;
            tdi_d  = 1'b0;
            if (bus.start) begin
                sr_d    = bus.instr;
                state_d = SEL_DR;
                cnt_d   = '0;
                div_d   = '0;
                phase_d = 1'b0;
                tms_d   = 1'b1;
                busy_d  = 1'b1;
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + DIV_ONE;
        end else if (!phase_q) begin
            div_d   = '0;
            phase_d = 1'b1;
            tck_d   = 1'b1;
            if (sample) begin
                shcap_d = cap_shift;
            end
        end else begin
            // End of a bit: present the next bit's tms/tdi with tck low
            div_d   = '0;
            phase_d = 1'b0;
            tck_d   = 1'b0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            cnt_d   = '0;
            unique case (state_q)
                RESET_SEQ: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        tms_d = ((cnt_q + CNT_ONE) != RST_LAST);
                    end
                end
                SEL_DR: begin
                    state_d = SEL_IR;
                    tms_d   = 1'b1;
                end
                SEL_IR: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    tdi_d = sr_q[0];
                    sr_d  = sr_q >> 1;
                    if (cnt_q == SHIFT_LAST) begin
                        state_d = EXIT1;
                        tms_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                EXIT1: begin
                    state_d = UPDATE;
                    tms_d   = 1'b1;
                end
                UPDATE: begin
                    state_d = RETURN;
                end
                RETURN: begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    captured_d = shcap_q;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.captured = captured_q;
    assign bus.tck      = tck_q;
    assign bus.tms      = tms_q;
    assign bus.tdi      = tdi_q;
endmodule
`default_nettype wire

// File: tb/tb_jtag_ir_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_ir_driver
// Brief    : Directed bench for jtag_ir_driver with a small TAP/IR model.
// Revision : 1.0
// ============================================================================
module tb_jtag_ir_driver;
    localparam int IRA = 2, DIVA = 2, IRB = 4, DIVB = 1;
    localparam int T_TLR = 0, T_CIR = 10, T_SHIR = 11, T_UIR = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_ir_driver_if #(.IR_WIDTH(IRA)) ifa ();
    jtag_ir_driver_if #(.IR_WIDTH(IRB)) ifb ();

    jtag_ir_driver #(.IR_WIDTH(IRA), .CLK_DIV(DIVA)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    jtag_ir_driver #(.IR_WIDTH(IRB), .CLK_DIV(DIVB)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // Target TAP with a 2-bit IR whose capture value is 2'b01
    int         tap_st = T_TLR;
    logic [1:0] tap_sh = 2'b00;
    logic [1:0] tap_ir = 2'b11;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            0:  return m ? 0  : 1;
            1:  return m ? 2  : 1;
            2:  return m ? 9  : 3;
            3:  return m ? 5  : 4;
            4:  return m ? 5  : 4;
            5:  return m ? 8  : 6;
            6:  return m ? 7  : 6;
            7:  return m ? 8  : 4;
            8:  return m ? 2  : 1;
            9:  return m ? 0  : 10;
            10: return m ? 12 : 11;
            11: return m ? 12 : 11;
            12: return m ? 15 : 13;
            13: return m ? 14 : 13;
            14: return m ? 15 : 11;
            default: return m ? 2 : 1;
        endcase
    endfunction

    always @(posedge ifa.tck) begin
        case (tap_st)
            T_CIR:  tap_sh <= 2'b01;
            T_SHIR: tap_sh <= {ifa.tdi, tap_sh[1]};
            T_UIR:  tap_ir <= tap_sh;
            T_TLR:  tap_ir <= 2'b11;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, ifa.tms);
    end

    assign ifa.tdo = (tap_st == T_SHIR) ? tap_sh[0] : 1'b0;
    assign ifb.tdo = 1'b0;

    wire dec_mode = (tap_ir == 2'd0) || (tap_ir == 2'd2);
    wire dec_sel  = (tap_ir == 2'd3);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the most recent run_mon call
    int          m_k, m_nbits, m_done_early;
    logic        m_done_end, m_timeout;
    logic        m_k1_busy, m_k1_tck, m_k1_tms;
    logic [15:0] m_tms, m_tdi;
    logic [31:0] m_cap;

    // Steps cycle by cycle from t+1 until busy drops, logging tms/tdi per TCK rise
    task automatic run_mon(input bit sel_b, input int pulse_at, input bit hold);
        logic prev, b, t, ms, di, dn;
        prev = 1'b0; m_nbits = 0; m_tms = '0; m_tdi = '0;
        m_done_early = 0; m_timeout = 1'b1; m_k = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            b  = sel_b ? ifb.busy : ifa.busy;
            t  = sel_b ? ifb.tck  : ifa.tck;
            ms = sel_b ? ifb.tms  : ifa.tms;
            di = sel_b ? ifb.tdi  : ifa.tdi;
            dn = sel_b ? ifb.done : ifa.done;
            if (k == 1) begin
                m_k1_busy = b; m_k1_tck = t; m_k1_tms = ms;
                if (sel_b) ifb.instr = ~ifb.instr;
                else       ifa.instr = ~ifa.instr;
            end
            if (!b) begin
                m_k = k; m_done_end = dn; m_timeout = 1'b0;
                m_cap = sel_b ? 32'(ifb.captured) : 32'(ifa.captured);
                break;
            end
            if (dn) m_done_early++;
            if (t && !prev && m_nbits < 16) begin
                m_tms[m_nbits] = ms;
                m_tdi[m_nbits] = di;
                m_nbits++;
            end
            prev = t;
            if (k == pulse_at) begin
                if (sel_b) ifb.start = 1'b1; else ifa.start = 1'b1;
            end else if (!hold) begin
                if (sel_b) ifb.start = 1'b0; else ifa.start = 1'b0;
            end
        end
        if (m_timeout) check("busy_timeout", 32'(m_timeout), 32'd0);
    endtask

    task automatic check_load(input string tag, input int k_exp, input int nb_exp,
                              input logic [15:0] tms_exp, input logic [15:0] tdi_exp,
                              input logic [31:0] cap_exp);
        check({tag, "_done_cycle"}, 32'(m_k), 32'(k_exp));
        check({tag, "_done"}, 32'(m_done_end), 32'd1);
        check({tag, "_early_done"}, 32'(m_done_early), 32'd0);
        check({tag, "_nbits"}, 32'(m_nbits), 32'(nb_exp));
        check({tag, "_tms"}, 32'(m_tms), 32'(tms_exp));
        check({tag, "_tdi"}, 32'(m_tdi), 32'(tdi_exp));
        check({tag, "_captured"}, m_cap, cap_exp);
    endtask

    initial begin
        int extra;
        ifa.start = 1'b0; ifa.instr = '0;
        ifb.start = 1'b0; ifb.instr = '0;

        // Reset held three cycles, then the 6-bit reset walk
        repeat (3) @(negedge clk);
        check("rst_tck", 32'(ifa.tck), 32'd0);
        check("rst_tms", 32'(ifa.tms), 32'd1);
        check("rst_busy", 32'(ifa.busy), 32'd1);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_captured", 32'(ifa.captured), 32'd0);
        rst = 1'b0;
        run_mon(1'b0, 0, 1'b0);
        check("rseq_len", 32'(m_k), 32'd24);
        check("rseq_nbits", 32'(m_nbits), 32'd6);
        check("rseq_tms", 32'(m_tms), 32'h1F);
        check("rseq_tdi", 32'(m_tdi), 32'h0);
        check("rseq_done", 32'(m_done_end) + 32'(m_done_early), 32'd0);
        check("rseq_tap_rti", 32'(tap_st), 32'd1);

        // BYPASS with a stray start pulse mid-load
        @(negedge clk);
        ifa.instr = 2'b11; ifa.start = 1'b1;
        run_mon(1'b0, 5, 1'b0);
        check_load("bypass", 33, 8, 16'h63, 16'h30, 32'h1);
        check("bypass_k1_busy", 32'(m_k1_busy), 32'd1);
        check("bypass_mode", 32'(dec_mode), 32'd0);
        check("bypass_sel", 32'(dec_sel), 32'd1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.tck || ifa.busy) extra++;
        end
        check("ignored_start", 32'(extra), 32'd0);

        // INTEST with start held, followed back-to-back by EXTEST
        ifa.instr = 2'b10; ifa.start = 1'b1;
        run_mon(1'b0, 0, 1'b1);
        check_load("intest", 33, 8, 16'h63, 16'h20, 32'h1);
        check("intest_ir", 32'(tap_ir), 32'd2);
        check("intest_mode", 32'(dec_mode), 32'd1);
        check("intest_sel", 32'(dec_sel), 32'd0);
        ifa.instr = 2'b00;
        run_mon(1'b0, 0, 1'b0);
        check("b2b_busy", 32'(m_k1_busy), 32'd1);
        check("b2b_tck", 32'(m_k1_tck), 32'd0);
        check("b2b_tms", 32'(m_k1_tms), 32'd1);
        check_load("extest", 33, 8, 16'h63, 16'h00, 32'h1);
        check("extest_ir", 32'(tap_ir), 32'd0);
        check("extest_mode", 32'(dec_mode), 32'd1);
        check("extest_sel", 32'(dec_sel), 32'd0);

        // Reset during shift bit 1 (bit 5 low phase)
        @(negedge clk);
        ifa.instr = 2'b11; ifa.start = 1'b1;
        extra = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            if (ifa.done) extra++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_tck", 32'(ifa.tck), 32'd0);
        check("abort_tms", 32'(ifa.tms), 32'd1);
        check("abort_busy", 32'(ifa.busy), 32'd1);
        check("abort_done", 32'(ifa.done) + 32'(extra), 32'd0);
        check("abort_captured", 32'(ifa.captured), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_mon(1'b0, 0, 1'b0);
        check("replay_len", 32'(m_k), 32'd24);
        check("replay_tms", 32'(m_tms), 32'h1F);
        check("replay_nbits", 32'(m_nbits), 32'd6);
        check("replay_done", 32'(m_done_end) + 32'(m_done_early), 32'd0);

        // CLK_DIV=1, IR_WIDTH=4 instance
        @(negedge clk);
        ifb.instr = 4'b1010; ifb.start = 1'b1;
        run_mon(1'b1, 0, 1'b0);
        check_load("w4", 21, 10, 16'h183, 16'h0A0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
